// File: rtl/keypad_pkg.sv
// -----------------------------------------------------------------------------
// keypad_pkg
// Shared types and constants for the 4x3 matrix keypad scanner.
//   state_t         : scanner FSM state encoding
//   ROW0..ROW3      : one-hot row strobes, ROW0 = top row (1000)
//   COL0..COL2      : one-hot column codes, COL0 = left column (100)
//   key_index()     : one-hot row/column -> key index 1..12 (0 if invalid)
//   is_single_col() : true when exactly one column line is active
//   next_row()      : right rotation of the row strobe
// -----------------------------------------------------------------------------
package keypad_pkg;

    typedef enum logic [1:0] {
        ST_SCAN    = 2'd0,
        ST_CONFIRM = 2'd1,
        ST_HELD    = 2'd2,
        ST_RELEASE = 2'd3
    } state_t;

    localparam int NUM_ROWS = 4;
    localparam int NUM_COLS = 3;

    localparam logic [3:0] ROW0 = 4'b1000;
    localparam logic [3:0] ROW1 = 4'b0100;
    localparam logic [3:0] ROW2 = 4'b0010;
    localparam logic [3:0] ROW3 = 4'b0001;

    localparam logic [2:0] COL0 = 3'b100;
    localparam logic [2:0] COL1 = 3'b010;
    localparam logic [2:0] COL2 = 3'b001;

    function automatic logic [3:0] key_index(input logic [3:0] row, input logic [2:0] col);
        logic [3:0] row_base;
        logic [3:0] col_off;
        logic       ok;
        ok = 1'b1;
        case (row)
            ROW0:    row_base = 4'd0;
            ROW1:    row_base = 4'd3;
            ROW2:    row_base = 4'd6;
            ROW3:    row_base = 4'd9;
            default: begin row_base = 4'd0; ok = 1'b0; end
        endcase
        case (col)
            COL0:    col_off = 4'd1;
            COL1:    col_off = 4'd2;
            COL2:    col_off = 4'd3;
            default: begin col_off = 4'd0; ok = 1'b0; end
        endcase
        return ok ? (row_base + col_off) : 4'd0;
    endfunction

    function automatic logic is_single_col(input logic [2:0] col);
        return (col == COL0) || (col == COL1) || (col == COL2);
    endfunction

    function automatic logic [3:0] next_row(input logic [3:0] row);
        return {row[0], row[3:1]};
    endfunction

endpackage

// File: rtl/keypad_sync.sv
// -----------------------------------------------------------------------------
// keypad_sync
// Two-flop synchronizer for the asynchronous keypad column sense lines.
// Ports:
//   i_clk   : system clock
//   i_rst   : asynchronous reset, active-high (flops clear to 0)
//   i_async : raw input, asynchronous to i_clk
//   o_sync  : synchronized copy, two clocks of latency
// -----------------------------------------------------------------------------
module keypad_sync #(
    parameter int WIDTH = 3
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [WIDTH-1:0] i_async,
    output logic [WIDTH-1:0] o_sync
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
        end
    end

    assign o_sync = r_sync;

endmodule

// File: rtl/keypad_scanner.sv
// -----------------------------------------------------------------------------
// keypad_scanner
// Active scanner for the 4-row x 3-column vending keypad. Strobes one row at a
// time, samples the synchronized column lines, debounces press and release and
// presents the confirmed key as held one-hot column/row codes, a 1..12 index
// and a one-cycle valid pulse.
//
// Ports:
//   clock_in       : system clock
//   reset_in       : asynchronous reset, active-high
//   coluna_pad_in  : raw column sense (3), active-high, asynchronous
//   linha_pad_out  : one-hot row strobe (4), 1000 = top row
//   coluna_out     : held one-hot column of the confirmed key, 000 when none
//   linha_out      : held one-hot row of the confirmed key, 0000 when none
//   key_code_out   : key index row*3+col+1, 0 when none
//   key_valid_out  : one-cycle pulse on press confirmation
//   key_held_out   : high while a confirmed key is held
//
// Build option: define KEYPAD_AUTOREPEAT_EN to re-pulse key_valid_out while a
// key stays held (first repeat after 8*SCAN_DIV*DEB_CYCLES cycles, then every
// 2*SCAN_DIV*DEB_CYCLES cycles).
//
// state      | meaning
// -----------+-------------------------------------------------------------
// ST_SCAN    | dwell on current row, sample columns at end of dwell
// ST_CONFIRM | row frozen, count consecutive matches of candidate column
// ST_HELD    | key confirmed, outputs stable, watch for column change
// ST_RELEASE | count consecutive non-matches before declaring release
// -----------------------------------------------------------------------------
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV   = 16,
    parameter int DEB_CYCLES = 15
) (
    input  logic       clock_in,
    input  logic       reset_in,
    input  logic [2:0] coluna_pad_in,
    output logic [3:0] linha_pad_out,
    output logic [2:0] coluna_out,
    output logic [3:0] linha_out,
    output logic [3:0] key_code_out,
    output logic       key_valid_out,
    output logic       key_held_out
);

    localparam int DW = $clog2(SCAN_DIV) + 1;
    localparam int BW = $clog2(DEB_CYCLES) + 1;
    localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
    localparam logic [BW-1:0] DEB_DONE   = BW'(DEB_CYCLES);

    logic [2:0]    w_col_s;

    state_t        r_state,    w_state_nxt;
    logic [3:0]    r_row,      w_row_nxt;
    logic [DW-1:0] r_dwell,    w_dwell_nxt;
    logic [BW-1:0] r_deb,      w_deb_nxt;
    logic [2:0]    r_cand_col, w_cand_col_nxt;
    logic [2:0]    r_col_out,  w_col_out_nxt;
    logic [3:0]    r_row_out,  w_row_out_nxt;
    logic [3:0]    r_code,     w_code_nxt;
    logic          r_valid,    w_valid_nxt;
    logic          r_held,     w_held_nxt;

    logic [DW-1:0] w_dwell_inc;
    logic [BW-1:0] w_deb_inc;

`ifdef KEYPAD_AUTOREPEAT_EN
    localparam int RPT_FIRST = 8 * SCAN_DIV * DEB_CYCLES;
    localparam int RPT_NEXT  = 2 * SCAN_DIV * DEB_CYCLES;
    localparam int RW        = $clog2(RPT_FIRST) + 1;

    logic [RW-1:0] r_rpt,       w_rpt_nxt;
    logic          r_rpt_armed, w_rpt_armed_nxt;
    logic [RW-1:0] w_rpt_inc;
    logic [RW-1:0] w_rpt_limit;

    assign w_rpt_inc   = (r_rpt == {RW{1'b1}}) ? r_rpt : r_rpt + RW'(1);
    // The first repeat waits the long interval, later ones the short one.
    assign w_rpt_limit = r_rpt_armed ? RW'(RPT_NEXT) : RW'(RPT_FIRST);
`endif

    keypad_sync #(.WIDTH(3)) u_sync (
        .i_clk   (clock_in),
        .i_rst   (reset_in),
        .i_async (coluna_pad_in),
        .o_sync  (w_col_s)
    );

    // Saturating increments: counters never wrap.
    assign w_dwell_inc = (r_dwell == {DW{1'b1}}) ? r_dwell : r_dwell + DW'(1);
    assign w_deb_inc   = (r_deb == {BW{1'b1}}) ? r_deb : r_deb + BW'(1);

    always_ff @(posedge clock_in or posedge reset_in) begin
        if (reset_in) begin
            r_state    <= ST_SCAN;
            r_row      <= ROW0;
            r_dwell    <= '0;
            r_deb      <= '0;
            r_cand_col <= '0;
            r_col_out  <= '0;
            r_row_out  <= '0;
            r_code     <= '0;
            r_valid    <= 1'b0;
            r_held     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_row      <= w_row_nxt;
            r_dwell    <= w_dwell_nxt;
            r_deb      <= w_deb_nxt;
            r_cand_col <= w_cand_col_nxt;
            r_col_out  <= w_col_out_nxt;
            r_row_out  <= w_row_out_nxt;
            r_code     <= w_code_nxt;
            r_valid    <= w_valid_nxt;
            r_held     <= w_held_nxt;
        end
    end

`ifdef KEYPAD_AUTOREPEAT_EN
    always_ff @(posedge clock_in or posedge reset_in) begin
        if (reset_in) begin
            r_rpt       <= '0;
            r_rpt_armed <= 1'b0;
        end else begin
            r_rpt       <= w_rpt_nxt;
            r_rpt_armed <= w_rpt_armed_nxt;
        end
    end
`endif

    always_comb begin
        w_state_nxt    = r_state;
        w_row_nxt      = r_row;
        w_dwell_nxt    = '0;
        w_deb_nxt      = r_deb;
        w_cand_col_nxt = r_cand_col;
        w_col_out_nxt  = r_col_out;
        w_row_out_nxt  = r_row_out;
        w_code_nxt     = r_code;
        w_valid_nxt    = 1'b0;
        w_held_nxt     = r_held;
`ifdef KEYPAD_AUTOREPEAT_EN
        w_rpt_nxt       = '0;
        w_rpt_armed_nxt = r_rpt_armed;
`endif

        case (r_state)
            ST_SCAN: begin
                if (r_dwell == DWELL_LAST) begin
                    // Multi-hot columns are ghosting and count as no key.
                    if (is_single_col(w_col_s)) begin
                        w_cand_col_nxt = w_col_s;
                        w_deb_nxt      = '0;
                        w_state_nxt    = ST_CONFIRM;
                    end else begin
                        w_row_nxt = next_row(r_row);
                    end
                end else begin
                    w_dwell_nxt = w_dwell_inc;
                end
            end

            ST_CONFIRM: begin
                if (w_col_s == r_cand_col) begin
                    if (w_deb_inc == DEB_DONE) begin
                        w_col_out_nxt = r_cand_col;
                        w_row_out_nxt = r_row;
                        w_code_nxt    = key_index(r_row, r_cand_col);
                        w_held_nxt    = 1'b1;
                        w_valid_nxt   = 1'b1;
                        w_deb_nxt     = '0;
                        w_state_nxt   = ST_HELD;
`ifdef KEYPAD_AUTOREPEAT_EN
                        w_rpt_armed_nxt = 1'b0;
`endif
                    end else begin
                        w_deb_nxt = w_deb_inc;
                    end
                end else begin
                    w_deb_nxt   = '0;
                    w_row_nxt   = next_row(r_row);
                    w_state_nxt = ST_SCAN;
                end
            end

            ST_HELD: begin
                if (w_col_s != r_cand_col) begin
                    w_deb_nxt   = '0;
                    w_state_nxt = ST_RELEASE;
                end else begin
`ifdef KEYPAD_AUTOREPEAT_EN
                    if (w_rpt_inc == w_rpt_limit) begin
                        w_valid_nxt     = 1'b1;
                        w_rpt_nxt       = '0;
                        w_rpt_armed_nxt = 1'b1;
                    end else begin
                        w_rpt_nxt = w_rpt_inc;
                    end
`endif
                end
            end

            ST_RELEASE: begin
                if (w_col_s == r_cand_col) begin
                    // Release glitch: back to held, no new valid pulse.
                    w_state_nxt = ST_HELD;
`ifdef KEYPAD_AUTOREPEAT_EN
                    w_rpt_armed_nxt = 1'b0;
`endif
                end else if (w_deb_inc == DEB_DONE) begin
                    w_col_out_nxt = '0;
                    w_row_out_nxt = '0;
                    w_code_nxt    = '0;
                    w_held_nxt    = 1'b0;
                    w_deb_nxt     = '0;
                    w_row_nxt     = next_row(r_row);
                    w_state_nxt   = ST_SCAN;
                end else begin
                    w_deb_nxt = w_deb_inc;
                end
            end

            default: begin
                w_state_nxt = ST_SCAN;
            end
        endcase
    end

    assign linha_pad_out = r_row;
    assign coluna_out    = r_col_out;
    assign linha_out     = r_row_out;
    assign key_code_out  = r_code;
    assign key_valid_out = r_valid;
    assign key_held_out  = r_held;

endmodule

// File: tb/tb_keypad_scanner.sv
// -----------------------------------------------------------------------------
// tb_keypad_scanner
// Keypad scanner bench: a physical keypad model drives the column lines from
// the strobed row, and a cycle model of the scanning rules predicts every
// output on every cycle. Directed scenarios add literal expectations.
// -----------------------------------------------------------------------------
module tb_keypad_scanner;

    localparam int S = 4;
    localparam int D = 3;

    logic       clock_in = 1'b0;
    logic       reset_in = 1'b1;
    logic [2:0] coluna_pad_in;
    logic [3:0] linha_pad_out;
    logic [2:0] coluna_out;
    logic [3:0] linha_out;
    logic [3:0] key_code_out;
    logic       key_valid_out;
    logic       key_held_out;

    int vectors     = 0;
    int miscompares = 0;
    int n_valid     = 0;

    logic [11:0] key_mask = '0;   // bit r*3+c: key at row r (0=top), column c (0=left)
    logic [2:0]  phys_col;

    keypad_scanner #(.SCAN_DIV(S), .DEB_CYCLES(D)) dut (
        .clock_in      (clock_in),
        .reset_in      (reset_in),
        .coluna_pad_in (coluna_pad_in),
        .linha_pad_out (linha_pad_out),
        .coluna_out    (coluna_out),
        .linha_out     (linha_out),
        .key_code_out  (key_code_out),
        .key_valid_out (key_valid_out),
        .key_held_out  (key_held_out)
    );

    always #5 clock_in = ~clock_in;

    // Matrix: a pressed key connects its row strobe to its column line.
    always_comb begin
        phys_col = '0;
        for (int r = 0; r < 4; r++)
            if (linha_pad_out[3-r])
                for (int c = 0; c < 3; c++)
                    if (key_mask[r*3+c]) phys_col[2-c] = 1'b1;
    end
    assign coluna_pad_in = phys_col;

    // Behavioural reference: row index, cycles spent on the row, phase
    // (0 scan, 1 confirm, 2 held, 3 release), run length, candidate column.
    int         m_row, m_dwell, m_phase, m_run, m_cand;
    logic [2:0] m_col;
    logic [3:0] m_lin;
    int         m_code;
    logic       m_valid, m_held;
    logic [2:0] d0, d1, pend;

    function automatic int col_idx(input logic [2:0] c);
        if (c == 3'b100) return 0;
        if (c == 3'b010) return 1;
        if (c == 3'b001) return 2;
        return -1;
    endfunction

    task automatic model_reset();
        m_row = 0; m_dwell = 0; m_phase = 0; m_run = 0; m_cand = 0;
        m_col = '0; m_lin = '0; m_code = 0; m_valid = 1'b0; m_held = 1'b0;
    endtask

    task automatic model_step(input logic [2:0] cs);
        logic [2:0] cand_col;
        cand_col = 3'b100 >> m_cand;
        m_valid = 1'b0;
        case (m_phase)
            0: begin
                if (m_dwell == S - 1) begin
                    m_dwell = 0;
                    if (col_idx(cs) >= 0) begin
                        m_cand = col_idx(cs); m_run = 0; m_phase = 1;
                    end else m_row = (m_row + 1) % 4;
                end else m_dwell++;
            end
            1: begin
                if (cs == cand_col) begin
                    m_run++;
                    if (m_run == D) begin
                        m_col = cand_col; m_lin = 4'b1000 >> m_row;
                        m_code = m_row * 3 + m_cand + 1;
                        m_held = 1'b1; m_valid = 1'b1; m_phase = 2;
                    end
                end else begin
                    m_row = (m_row + 1) % 4; m_dwell = 0; m_phase = 0;
                end
            end
            2: if (cs != cand_col) begin m_phase = 3; m_run = 0; end
            default: begin
                if (cs == cand_col) m_phase = 2;
                else begin
                    m_run++;
                    if (m_run == D) begin
                        m_col = '0; m_lin = '0; m_code = 0; m_held = 1'b0;
                        m_row = (m_row + 1) % 4; m_dwell = 0; m_phase = 0;
                    end
                end
            end
        endcase
    endtask

    // Per-cycle compare; the model advances by the posedge that just passed,
    // using the pad value seen two edges earlier (synchronizer latency).
    always @(negedge clock_in) begin
        logic [3:0] exp_row;
        if (reset_in) begin
            model_reset(); d0 = '0; d1 = '0;
        end else begin
            model_step(d1); d1 = d0; d0 = pend;
        end
        exp_row = 4'b1000 >> m_row;
        vectors++;
        if (linha_pad_out !== exp_row || coluna_out !== m_col || linha_out !== m_lin ||
            key_code_out !== 4'(m_code) || key_valid_out !== m_valid || key_held_out !== m_held) begin
            miscompares++;
            $display("FAIL cycle t=%0t got row=%b col=%b lin=%b code=%0d v=%b h=%b want row=%b col=%b lin=%b code=%0d v=%b h=%b",
                     $time, linha_pad_out, coluna_out, linha_out, key_code_out, key_valid_out, key_held_out,
                     exp_row, m_col, m_lin, m_code, m_valid, m_held);
        end
        if (key_valid_out) n_valid++;
        pend = coluna_pad_in;
    end

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin @(posedge clock_in); #2; end
    endtask

    task automatic release_reset();
        @(negedge clock_in); #2; reset_in = 1'b0;
    endtask

    task automatic random_key(output logic [11:0] m);
        m = 12'd1 << $urandom_range(0, 11);
        if ($urandom_range(0, 3) == 0) m = m | (12'd1 << $urandom_range(0, 11));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int v0;
        logic [11:0] m;

        // Reset, no key.
        cyc(3);
        chk("rst_row", int'(linha_pad_out), 8);
        chk("rst_code", int'(key_code_out), 0);
        chk("rst_held", int'(key_held_out), 0);
        release_reset();
        v0 = n_valid;
        repeat (4) @(posedge clock_in);
        @(negedge clock_in); #1;
        chk("row_after_dwell", int'(linha_pad_out), 4);
        cyc(40);
        chk("idle_valid", n_valid - v0, 0);
        chk("idle_code", int'(key_code_out), 0);

        // Clean press of key 5 (row 0100, column 010).
        v0 = n_valid;
        key_mask = 12'd1 << 4;
        cyc(100);
        chk("k5_col", int'(coluna_out), 2);
        chk("k5_lin", int'(linha_out), 4);
        chk("k5_code", int'(key_code_out), 5);
        chk("k5_held", int'(key_held_out), 1);
        chk("k5_pulses", n_valid - v0, 1);
        key_mask = '0;
        cyc(20);
        chk("k5_rel_code", int'(key_code_out), 0);
        chk("k5_rel_col", int'(coluna_out), 0);
        chk("k5_rel_held", int'(key_held_out), 0);

        // Press bounce.
        v0 = n_valid;
        repeat (4) begin
            key_mask = 12'd1 << 4; cyc(2);
            key_mask = '0;         cyc(1);
        end
        key_mask = 12'd1 << 4;
        cyc(60);
        chk("bounce_pulses", n_valid - v0, 1);
        chk("bounce_code", int'(key_code_out), 5);
        key_mask = '0;
        cyc(20);

        // Release bounce.
        v0 = n_valid;
        key_mask = 12'd1 << 4; cyc(40);
        key_mask = '0;         cyc(2);
        key_mask = 12'd1 << 4; cyc(10);
        chk("glitch_held", int'(key_held_out), 1);
        chk("glitch_code", int'(key_code_out), 5);
        key_mask = '0;
        cyc(20);
        chk("glitch_pulses", n_valid - v0, 1);
        chk("glitch_rel_held", int'(key_held_out), 0);

        // Ghosting on the top row plus bottom-right key.
        v0 = n_valid;
        key_mask = (12'd1 << 0) | (12'd1 << 1) | (12'd1 << 11);
        cyc(60);
        chk("ghost_code", int'(key_code_out), 12);
        chk("ghost_col", int'(coluna_out), 1);
        chk("ghost_lin", int'(linha_out), 1);
        chk("ghost_pulses", n_valid - v0, 1);
        key_mask = '0;
        cyc(20);

        // Reset while key 7 is held.
        key_mask = 12'd1 << 6;
        cyc(60);
        chk("k7_code", int'(key_code_out), 7);
        @(posedge clock_in); #2; reset_in = 1'b1; #1;
        chk("arst_code", int'(key_code_out), 0);
        chk("arst_held", int'(key_held_out), 0);
        chk("arst_lin", int'(linha_out), 0);
        chk("arst_row", int'(linha_pad_out), 8);
        cyc(3);
        release_reset();
        v0 = n_valid;
        cyc(60);
        chk("k7_again_pulses", n_valid - v0, 1);
        chk("k7_again_code", int'(key_code_out), 7);
        key_mask = '0;
        cyc(20);

        // Randomized presses with bounce on both edges.
        repeat (40) begin
            random_key(m);
            repeat ($urandom_range(0, 4)) begin
                key_mask = m;  cyc($urandom_range(1, 3));
                key_mask = '0; cyc($urandom_range(1, 2));
            end
            key_mask = m;
            cyc($urandom_range(5, 70));
            repeat ($urandom_range(0, 3)) begin
                key_mask = '0; cyc($urandom_range(1, 3));
                key_mask = m;  cyc($urandom_range(1, 3));
            end
            key_mask = '0;
            cyc($urandom_range(3, 40));
        end

        cyc(5);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
